voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Command scheduler between the CPU→FPGA 32-bit command FIFO and a bank of NUM_VOICES tone/envelope voices (squaregen + envelope_generator pairs).
- Pops one command word at a time and allocates, retriggers, releases or steals voices.
- Per voice it drives a period, a one-cycle note_on pulse and a one-cycle note_off pulse.
- Replaces the single-voice "period changed" edge detector in the top level.

Parameters:
- NUM_VOICES, 4: number of voices managed; 2..8.
- PERIOD_W, 23: width of the tone period field.
- ID_W, 7: width of the note identifier.
- AGE_W, 8: width of the per-voice allocation-age counter; saturating.

Ports:
- clk  in  1  calculation clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  command FIFO empty flag.
- fifo_rden  out  1  FIFO read strobe; data is valid on fifo_data the cycle after.
- fifo_data  in  32  command word.
- voice_busy  in  NUM_VOICES  per-voice envelope busy flag.
- voice_period  out  NUM_VOICES*PERIOD_W  per-voice period; voice v occupies bits [v*PERIOD_W +: PERIOD_W].
- voice_on  out  NUM_VOICES  one-cycle note_on pulses.
- voice_off  out  NUM_VOICES  one-cycle note_off pulses.
- voice_active  out  NUM_VOICES  1 while the voice is HELD.
- steal  out  1  one-cycle pulse when a HELD voice is stolen.

Behaviour:
- Reset (asynchronous, active-high): FSM to IDLE. All voices FREE, with period 0 and age 0. fifo_rden, voice_on, voice_off, voice_active and steal all 0. A command word in flight at reset is discarded.
- Command format:
  - [31:30] opcode: 00 NOP, 01 NOTE_ON, 10 NOTE_OFF, 11 ALL_OFF.
  - [29:23] note id.
  - [22:0] period.
  - NOTE_ON with period 0 is executed as NOTE_OFF for that id.
- Main FSM:
  - IDLE: fifo_rden = !fifo_empty, combinational. If it is asserted, go to FETCH.
  - FETCH: latch fifo_data into the command register, then go to EXEC.
  - EXEC: perform the command and update voice state and output registers, then go to IDLE.
  - Latency: fifo_rden high in cycle T gives pulses high in cycle T+3. Maximum throughput is one command per 3 cycles.
  - fifo_rden is never asserted outside IDLE.
- Per-voice state: FREE, HELD(id) or RELEASING.
- NOTE_ON, evaluated in this priority order:
  1. A HELD voice with the same id: retrigger. Update its period, pulse voice_on, reset its age to 0.
  2. Otherwise the lowest-index FREE voice.
  3. Otherwise the RELEASING voice with the largest age; lowest index on a tie.
  4. Otherwise steal the HELD voice with the largest age; lowest index on a tie. Pulse steal.
  - The chosen voice becomes HELD(id) with the new period, voice_on pulses, and its age resets to 0.
  - Every other non-FREE voice's age increments by 1, saturating at 2^AGE_W−1.
- NOTE_OFF: every HELD voice with a matching id pulses voice_off and becomes RELEASING; its period is retained. An unknown id is a no-op with no pulses.
- ALL_OFF: every HELD voice pulses voice_off simultaneously and becomes RELEASING.
- NOP: no state change.
- RELEASING → FREE: in any cycle at least 2 cycles after its voice_off pulse in which voice_busy[v]=0. This covers envelope busy lag.
- If a release completes in the same cycle as EXEC, the voice is still RELEASING for that EXEC's allocation decision.
- voice_period holds its value until the voice is reallocated; a FREE voice keeps its last period. Only reset clears it.
- voice_on and voice_off are never high simultaneously for the same voice.
- voice_active[v] = (state==HELD), registered.

Test Plan:
- Reset, push NOTE_ON id=5 period=1000 → voice_on[0] pulses 3 cycles after fifo_rden; period0=1000; voice_active=0001; steal=0.
- NOTE_ON id=1..4 periods 100..400 (NUM_VOICES=4), then NOTE_ON id=9 period=900 → voice 0 is stolen: steal=1, voice_on[0], period0=900, voice_active stays 1111.
- NOTE_ON id=3 period=50, then NOTE_ON id=3 period=60 → same voice retriggered, period=60, only one voice active.
- NOTE_OFF id=3 with voice_busy held 1 for 10 cycles → voice_off pulses once; the voice becomes FREE only after busy falls. NOTE_OFF id=7 (unknown) → no pulses.
- Fill all 4 voices, ALL_OFF → voice_off=1111 in one cycle, voice_active=0000. NOTE_ON while all are RELEASING → oldest RELEASING voice reused, steal=0.
- Assert rst between FETCH and EXEC of a NOTE_ON → no voice_on pulse; all outputs 0; the next command is processed normally after rst is released.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: pops 32-bit commands from the CPU command FIFO and maps them
// onto a bank of tone/envelope voices, handling allocation, retrigger, release
// and voice stealing.
//
// Ports:
//   clk           calculation clock, all logic on its rising edge
//   rst           asynchronous active-high reset
//   fifo_empty    command FIFO empty flag
//   fifo_rden     FIFO read strobe (combinational); data valid the next cycle
//   fifo_data     command word {op[31:30], id[29:23], period[22:0]}
//   voice_busy    per-voice envelope busy flags
//   voice_period  per-voice period, voice v at [v*PERIOD_W +: PERIOD_W]
//   voice_on      one-cycle note_on pulses
//   voice_off     one-cycle note_off pulses
//   voice_active  1 while the voice is held
//   steal         one-cycle pulse when a held voice is taken over
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PERIOD_W   = 23,
  parameter int unsigned ID_W       = 7,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  output logic                           fifo_rden,
  input  logic [31:0]                    fifo_data,
  input  logic [NUM_VOICES-1:0]          voice_busy,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES-1:0]          voice_on,
  output logic [NUM_VOICES-1:0]          voice_off,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic                           steal
);

  localparam int unsigned IDX_W   = $clog2(NUM_VOICES);
  localparam int unsigned RCNT_W  = 2;
  localparam logic [RCNT_W-1:0] REL_HOLDOFF = RCNT_W'(2);
  localparam logic [AGE_W-1:0]  AGE_MAX     = '1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ON   = 2'b01;
  localparam logic [1:0] OP_OFF  = 2'b10;
  localparam logic [1:0] OP_ALL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_REL}   vstate_t;

  state_t state_q, state_d;
  logic   cmd_load;
  logic   exec;

  logic [31:0] cmd_q;
  logic [1:0]          cmd_op;
  logic [ID_W-1:0]     cmd_id;
  logic [PERIOD_W-1:0] cmd_per;

  vstate_t             v_state_q [NUM_VOICES];
  vstate_t             v_state_d [NUM_VOICES];
  logic [ID_W-1:0]     v_id_q    [NUM_VOICES];
  logic [ID_W-1:0]     v_id_d    [NUM_VOICES];
  logic [AGE_W-1:0]    v_age_q   [NUM_VOICES];
  logic [AGE_W-1:0]    v_age_d   [NUM_VOICES];
  logic [PERIOD_W-1:0] v_per_q   [NUM_VOICES];
  logic [PERIOD_W-1:0] v_per_d   [NUM_VOICES];
  logic [RCNT_W-1:0]   v_rcnt_q  [NUM_VOICES];
  logic [RCNT_W-1:0]   v_rcnt_d  [NUM_VOICES];

  logic [NUM_VOICES-1:0] on_d, off_d, act_d;
  logic                  steal_d;

  logic             do_on, do_off, do_all;
  logic             hit_found, free_found, rel_found, held_seen;
  logic [IDX_W-1:0] hit_idx, free_idx, rel_idx, held_idx, alloc_idx;
  logic [AGE_W-1:0] rel_age, held_age;
  logic             alloc_steal;

  // Main FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Main FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_rden) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Main FSM: outputs; the read strobe is combinational so a pop can start in IDLE
  always_comb begin
    fifo_rden = 1'b0;
    cmd_load  = 1'b0;
    exec      = 1'b0;
    case (state_q)
      S_IDLE:  fifo_rden = !fifo_empty && !rst;
      S_FETCH: cmd_load  = 1'b1;
      S_EXEC:  exec      = 1'b1;
      default: ;
    endcase
  end

  // Command register, loaded from the FIFO the cycle after the read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cmd_q <= '0;
    else if (cmd_load) cmd_q <= fifo_data;
  end

  assign cmd_op  = cmd_q[31:30];
  assign cmd_id  = cmd_q[PERIOD_W +: ID_W];
  assign cmd_per = cmd_q[PERIOD_W-1:0];

  // A NOTE_ON with a zero period behaves as a NOTE_OFF for its id
  assign do_on  = exec && (cmd_op == OP_ON) && (cmd_per != '0);
  assign do_off = exec && ((cmd_op == OP_OFF) || ((cmd_op == OP_ON) && (cmd_per == '0)));
  assign do_all = exec && (cmd_op == OP_ALL);

  // Candidate search; strict '>' keeps the lowest index on age ties
  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    rel_found  = 1'b0;
    held_seen  = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    rel_idx    = '0;
    held_idx   = '0;
    rel_age    = '0;
    held_age   = '0;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      if (v_state_q[v] == V_HELD && v_id_q[v] == cmd_id && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(v);
      end
      if (v_state_q[v] == V_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
      if (v_state_q[v] == V_REL && (!rel_found || v_age_q[v] > rel_age)) begin
        rel_found = 1'b1;
        rel_idx   = IDX_W'(v);
        rel_age   = v_age_q[v];
      end
      if (v_state_q[v] == V_HELD && (!held_seen || v_age_q[v] > held_age)) begin
        held_seen = 1'b1;
        held_idx  = IDX_W'(v);
        held_age  = v_age_q[v];
      end
    end
  end

  // Allocation priority: retrigger, free, oldest releasing, steal oldest held
  always_comb begin
    alloc_idx   = held_idx;
    alloc_steal = 1'b0;
    if (hit_found)       alloc_idx = hit_idx;
    else if (free_found) alloc_idx = free_idx;
    else if (rel_found)  alloc_idx = rel_idx;
    else                 alloc_steal = 1'b1;
  end

  // Per-voice next state; command effects override release completion
  always_comb begin
    v_state_d = v_state_q;
    v_id_d    = v_id_q;
    v_age_d   = v_age_q;
    v_per_d   = v_per_q;
    v_rcnt_d  = v_rcnt_q;
    on_d      = '0;
    off_d     = '0;
    act_d     = '0;
    steal_d   = do_on && alloc_steal;
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      // Hold-off of two cycles after voice_off covers the envelope busy lag
      if (v_state_q[v] == V_REL) begin
        if (v_rcnt_q[v] != REL_HOLDOFF) v_rcnt_d[v] = v_rcnt_q[v] + RCNT_W'(1);
        else if (!voice_busy[v])        v_state_d[v] = V_FREE;
      end
      if (do_on) begin
        if (IDX_W'(v) == alloc_idx) begin
          v_state_d[v] = V_HELD;
          v_id_d[v]    = cmd_id;
          v_per_d[v]   = cmd_per;
          v_age_d[v]   = '0;
          v_rcnt_d[v]  = '0;
          on_d[v]      = 1'b1;
        end else if (v_state_q[v] != V_FREE && v_age_q[v] != AGE_MAX) begin
          v_age_d[v] = v_age_q[v] + AGE_W'(1);
        end
      end
      if (v_state_q[v] == V_HELD && (do_all || (do_off && v_id_q[v] == cmd_id))) begin
        v_state_d[v] = V_REL;
        v_rcnt_d[v]  = '0;
        off_d[v]     = 1'b1;
      end
      act_d[v] = (v_state_d[v] == V_HELD);
    end
  end

  // Voice state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < int'(NUM_VOICES); v++) begin
        v_state_q[v] <= V_FREE;
        v_id_q[v]    <= '0;
        v_age_q[v]   <= '0;
        v_per_q[v]   <= '0;
        v_rcnt_q[v]  <= '0;
      end
      voice_on     <= '0;
      voice_off    <= '0;
      voice_active <= '0;
      steal        <= 1'b0;
    end else begin
      v_state_q    <= v_state_d;
      v_id_q       <= v_id_d;
      v_age_q      <= v_age_d;
      v_per_q      <= v_per_d;
      v_rcnt_q     <= v_rcnt_d;
      voice_on     <= on_d;
      voice_off    <= off_d;
      voice_active <= act_d;
      steal        <= steal_d;
    end
  end

  // Pack the period registers onto the flat output bus
  for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_per
    assign voice_period[g*PERIOD_W +: PERIOD_W] = v_per_q[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed table, corner sequences and randomized commands
// against a behavioural model of voice allocation.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int PW = 23;
  localparam int BH_N = 16384;

  typedef struct {
    logic [31:0]   cmd;
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    logic          st;
    logic [NV-1:0] act;
    int            vidx;
    int            per;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty;
  logic              fifo_rden;
  logic [31:0]       fifo_data = '0;
  logic [NV-1:0]     voice_busy = '0;
  logic [NV*PW-1:0]  voice_period;
  logic [NV-1:0]     voice_on, voice_off, voice_active;
  logic              steal;

  int n_vec = 0;
  int n_bad = 0;

  // Command FIFO model: written by the stimulus, popped on fifo_rden
  logic [31:0] mem [0:4095];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  // Busy history per cycle, used by the reference model for release timing
  logic [NV-1:0] bh [0:BH_N-1];
  int cyc = 0;

  bit rand_busy = 1'b0;

  // Reference model state
  bit   m_held [NV];
  bit   m_rel  [NV];
  int   m_id   [NV];
  int   m_age  [NV];
  int   m_off  [NV];
  logic [PW-1:0] m_per [NV];

  vec_t tab [14];

  voice_allocator #(.NUM_VOICES(NV), .PERIOD_W(PW), .ID_W(7), .AGE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rden    (fifo_rden),
    .fifo_data    (fifo_data),
    .voice_busy   (voice_busy),
    .voice_period (voice_period),
    .voice_on     (voice_on),
    .voice_off    (voice_off),
    .voice_active (voice_active),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rden) begin
      fifo_data <= mem[rd_cnt];
      rd_cnt    <= rd_cnt + 1;
    end
    if (cyc < BH_N) bh[cyc] <= voice_busy;
    cyc <= cyc + 1;
  end

  function automatic logic [31:0] mk(input int op, input int id, input int per);
    return {2'(op), 7'(id), 23'(per)};
  endfunction

  function automatic logic [PW-1:0] vper(input int v);
    return voice_period[v*PW +: PW];
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_held[v] = 0; m_rel[v] = 0; m_id[v] = 0;
      m_age[v] = 0; m_off[v] = 0; m_per[v] = '0;
    end
  endtask

  // A releasing voice is free at cycle e if, in some earlier cycle at least
  // two cycles after its voice_off pulse, its busy flag was low.
  function automatic bit m_released(input int v, input int e);
    for (int c = m_off[v] + 2; c < e; c++)
      if (c >= 0 && c < BH_N && !bh[c][v]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_exec(input logic [31:0] w, input int e,
                            output logic [NV-1:0] eon, output logic [NV-1:0] eoff,
                            output logic est);
    int op, id, per, pick;
    eon = '0; eoff = '0; est = 1'b0;
    op  = int'(w[31:30]);
    id  = int'(w[29:23]);
    per = int'(w[22:0]);
    for (int v = 0; v < NV; v++)
      if (m_rel[v] && m_released(v, e)) m_rel[v] = 0;
    if (op == 1 && per != 0) begin
      pick = -1;
      for (int v = 0; v < NV; v++)
        if (pick < 0 && m_held[v] && m_id[v] == id) pick = v;
      for (int v = 0; v < NV; v++)
        if (pick < 0 && !m_held[v] && !m_rel[v]) pick = v;
      if (pick < 0) begin
        for (int v = 0; v < NV; v++)
          if (m_rel[v] && (pick < 0 || m_age[v] > m_age[pick])) pick = v;
      end
      if (pick < 0) begin
        est = 1'b1;
        for (int v = 0; v < NV; v++)
          if (pick < 0 || m_age[v] > m_age[pick]) pick = v;
      end
      for (int v = 0; v < NV; v++)
        if (v != pick && (m_held[v] || m_rel[v]))
          m_age[v] = (m_age[v] < 255) ? m_age[v] + 1 : 255;
      m_held[pick] = 1; m_rel[pick] = 0; m_id[pick] = id;
      m_per[pick] = PW'(per); m_age[pick] = 0;
      eon[pick] = 1'b1;
    end else if (op == 1 || op == 2 || op == 3) begin
      for (int v = 0; v < NV; v++)
        if (m_held[v] && (op == 3 || m_id[v] == id)) begin
          m_held[v] = 0; m_rel[v] = 1; m_off[v] = e + 1;
          eoff[v] = 1'b1;
        end
    end
  endtask

  // Push one command at the current cycle T and check through cycle T+3
  task automatic send(input logic [31:0] w, input bit use_tab, input vec_t r, input string nm);
    logic [NV-1:0]    eon, eoff, eact;
    logic             est;
    logic [NV*PW-1:0] eper;
    int t;
    mem[wr_cnt % 4096] = w;
    wr_cnt++;
    #1;
    chk({nm, " rden"}, 128'(fifo_rden), 128'(1));
    t = cyc;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (rand_busy) voice_busy = NV'($urandom);
      #1;
      chk($sformatf("%s quiet%0d", nm, k), 128'({voice_on, voice_off, steal, fifo_rden}), 128'(0));
    end
    @(negedge clk);
    if (rand_busy) voice_busy = NV'($urandom);
    model_exec(w, t + 2, eon, eoff, est);
    eact = '0;
    for (int v = 0; v < NV; v++) begin
      eact[v] = m_held[v];
      eper[v*PW +: PW] = m_per[v];
    end
    #1;
    if (use_tab) begin
      chk({nm, " on"},     128'(voice_on),       128'(r.on));
      chk({nm, " off"},    128'(voice_off),      128'(r.off));
      chk({nm, " steal"},  128'(steal),          128'(r.st));
      chk({nm, " active"}, 128'(voice_active),   128'(r.act));
      chk({nm, " period"}, 128'(vper(r.vidx)),   128'(r.per));
    end else begin
      chk({nm, " on"},     128'(voice_on),       128'(eon));
      chk({nm, " off"},    128'(voice_off),      128'(eoff));
      chk({nm, " steal"},  128'(steal),          128'(est));
      chk({nm, " active"}, 128'(voice_active),   128'(eact));
      chk({nm, " period"}, 128'(voice_period),   128'(eper));
    end
  endtask

  task automatic sendv(input vec_t r, input string nm);
    send(r.cmd, 1'b1, r, nm);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " on"},     128'(voice_on),     128'(0));
    chk({nm, " off"},    128'(voice_off),    128'(0));
    chk({nm, " active"}, 128'(voice_active), 128'(0));
    chk({nm, " steal"},  128'(steal),        128'(0));
    chk({nm, " period"}, 128'(voice_period), 128'(0));
    chk({nm, " rden"},   128'(fifo_rden),    128'(0));
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs(nm);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    vec_t dummy;
    logic [31:0] w;
    int op, gap;

    dummy = '{32'h0, 4'b0, 4'b0, 1'b0, 4'b0, 0, 0};
    //            cmd               on       off      st    act      vidx per
    tab[0]  = '{mk(1, 5, 1000), 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 1000};
    tab[1]  = '{mk(1, 1, 100),  4'b0010, 4'b0000, 1'b0, 4'b0011, 1, 100};
    tab[2]  = '{mk(1, 2, 200),  4'b0100, 4'b0000, 1'b0, 4'b0111, 2, 200};
    tab[3]  = '{mk(1, 3, 300),  4'b1000, 4'b0000, 1'b0, 4'b1111, 3, 300};
    tab[4]  = '{mk(1, 9, 900),  4'b0001, 4'b0000, 1'b1, 4'b1111, 0, 900};
    tab[5]  = '{mk(1, 3, 60),   4'b1000, 4'b0000, 1'b0, 4'b1111, 3, 60};
    tab[6]  = '{mk(2, 3, 0),    4'b0000, 4'b1000, 1'b0, 4'b0111, 3, 60};
    tab[7]  = '{mk(2, 7, 0),    4'b0000, 4'b0000, 1'b0, 4'b0111, 3, 60};
    tab[8]  = '{mk(1, 4, 400),  4'b1000, 4'b0000, 1'b0, 4'b1111, 3, 400};
    tab[9]  = '{mk(3, 0, 0),    4'b0000, 4'b1111, 1'b0, 4'b0000, 0, 900};
    tab[10] = '{mk(1, 20, 77),  4'b0010, 4'b0000, 1'b0, 4'b0010, 1, 77};
    tab[11] = '{mk(0, 0, 0),    4'b0000, 4'b0000, 1'b0, 4'b0010, 2, 200};
    tab[12] = '{mk(1, 0, 0),    4'b0000, 4'b0000, 1'b0, 4'b0010, 1, 77};
    tab[13] = '{mk(1, 20, 0),   4'b0000, 4'b0010, 1'b0, 4'b0000, 1, 77};

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 14; i++) sendv(tab[i], $sformatf("row%0d", i));

    // Retrigger, then release held off by a busy envelope
    do_reset("reset2");
    sendv('{mk(1, 3, 50), 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 50}, "retrig_a");
    sendv('{mk(1, 3, 60), 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 60}, "retrig_b");
    voice_busy = 4'b0001;
    sendv('{mk(2, 3, 0),  4'b0000, 4'b0001, 1'b0, 4'b0000, 0, 60}, "busy_off");
    repeat (10) @(negedge clk);
    sendv('{mk(1, 8, 5),  4'b0010, 4'b0000, 1'b0, 4'b0010, 1, 5},  "busy_hold");
    voice_busy = 4'b0000;
    repeat (3) @(negedge clk);
    sendv('{mk(1, 9, 6),  4'b0001, 4'b0000, 1'b0, 4'b0011, 0, 6},  "busy_free");

    // Reset arriving after FETCH, before the EXEC result is registered
    @(negedge clk);
    mem[wr_cnt % 4096] = mk(1, 5, 1000);
    wr_cnt++;
    #1;
    chk("midrst rden", 128'(fifo_rden), 128'(1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst_a");
    @(negedge clk);
    #1;
    chk_reset_outputs("midrst_b");
    rst = 1'b0;
    model_reset();
    sendv('{mk(1, 6, 123), 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 123}, "after_rst");

    // Randomized commands with random envelope busy flags
    rand_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0)      op = 0;
      else if (op <= 6) op = 1;
      else if (op <= 8) op = 2;
      else              op = 3;
      w = mk(op, int'($urandom_range(0, 5)),
             ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8388607)));
      send(w, 1'b0, dummy, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 3));
      if (gap > 1) repeat (gap - 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
